// File: rtl/nano_rx_pkg.sv
// Shared types and constants for the nano serial word receiver.
package nano_rx_pkg;

  localparam int WORD_W    = 16;
  localparam int BIT_CNT_W = $clog2(WORD_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/nano_rx_sync2.sv
// Two-flop synchronizer for an asynchronous, idle-high input.
module sync2 (
  input  logic ck,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Resolve metastability over two stages; resets to the idle (high) level.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/nano_rx.sv
// Oversampling deframer for the 16-bit nano serial line with a polled holding register.
module nano_rx
  import nano_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              linha,
  input  logic              rd,
  output logic [WORD_W-1:0] palavra,
  output logic              ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]        HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]        BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WORD_W - 1);

  logic                 line_s, prev_q, fall_s, half_s, cyc_end_s, stop_sample_s;
  rx_state_t            state_q, state_d;
  logic [CW-1:0]        cyc_q, cyc_d;
  logic [BIT_CNT_W-1:0] bit_q, bit_d;
  logic [WORD_W-1:0]    shreg_q, shreg_d, palavra_q, palavra_d;
  logic                 ready_q, ready_d, frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d, busy_q, busy_d;

  sync2 u_sync (.ck(ck), .rst(rst), .d(linha), .q(line_s));

  assign fall_s        = prev_q & ~line_s;
  assign half_s        = (cyc_q == HALF_END);
  assign cyc_end_s     = (cyc_q == BIT_END);
  assign stop_sample_s = (state_q == STOP) & cyc_end_s;

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fall_s) state_d = START; else state_d = IDLE;
      START:   if (half_s) state_d = line_s ? IDLE : DATA; else state_d = START;
      DATA:    if (cyc_end_s && (bit_q == LAST_BIT)) state_d = STOP; else state_d = DATA;
      STOP:    if (cyc_end_s) state_d = IDLE; else state_d = STOP;
      default: state_d = IDLE;
    endcase
  end

  // Counters and shift register; data bits enter at the MSB so the LSB lands at bit 0.
  always_comb begin
    cyc_d   = cyc_q + CW'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    case (state_q)
      IDLE: begin
        cyc_d = {CW{1'b0}};
        bit_d = {BIT_CNT_W{1'b0}};
      end
      START: if (half_s) cyc_d = {CW{1'b0}}; else cyc_d = cyc_q + CW'(1);
      DATA: begin
        if (cyc_end_s) begin
          cyc_d   = {CW{1'b0}};
          bit_d   = bit_q + BIT_CNT_W'(1);
          shreg_d = {line_s, shreg_q[WORD_W-1:1]};
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      STOP:    if (cyc_end_s) cyc_d = {CW{1'b0}}; else cyc_d = cyc_q + CW'(1);
      default: cyc_d = {CW{1'b0}};
    endcase
  end

  // Holding register and flags: a word load overrides a coincident read.
  always_comb begin
    palavra_d   = palavra_q;
    ready_d     = rd ? 1'b0 : ready_q;
    frame_err_d = rd ? 1'b0 : frame_err_q;
    overrun_d   = rd ? 1'b0 : overrun_q;
    busy_d      = (state_d != IDLE);
    if (stop_sample_s) begin
      if (line_s) begin
        palavra_d = shreg_q;
        ready_d   = 1'b1;
        overrun_d = rd ? 1'b0 : (overrun_q | ready_q);
      end else begin
        frame_err_d = 1'b1;
      end
    end else begin
      palavra_d = palavra_d;
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      prev_q      <= 1'b1;
      cyc_q       <= {CW{1'b0}};
      bit_q       <= {BIT_CNT_W{1'b0}};
      shreg_q     <= {WORD_W{1'b0}};
      palavra_q   <= {WORD_W{1'b0}};
      ready_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      prev_q      <= line_s;
      cyc_q       <= cyc_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      palavra_q   <= palavra_d;
      ready_q     <= ready_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign palavra   = palavra_q;
  assign ready     = ready_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule
